// File: rtl/avalon_debug_log_reader.sv
// Avalon-MM poller for a packed debug-trace word. Each poll computes how many
// events are new since the previous poll and replays them, oldest first,
// through a show-ahead FIFO with a valid/ready output.
module avalon_debug_log_reader #(
  parameter int POLL_INTERVAL = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_enable,
  output logic        io_Avalon_address,
  output logic        io_Avalon_read,
  input  logic [63:0] io_Avalon_readdata,
  output logic        io_Avalon_write,
  output logic [63:0] io_Avalon_writedata,
  input  logic        io_Avalon_waitrequest,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [4:0]  io_out_bits_info,
  output logic [7:0]  io_out_bits_seq,
  output logic        io_out_bits_lost,
  output logic [15:0] io_lostCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(POLL_INTERVAL + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_UNPACK = 2'd2
  } state_t;

  // Saturating accumulate of dropped events.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             read_q;
  logic [63:0]      word_q;
  logic [7:0]       last_q;
  logic [2:0]       k_q;
  logic             lost_pend_q;
  logic [15:0]      lost_cnt_q;

  logic [13:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic        accept;
  logic [7:0]  s_new;
  logic [7:0]  delta;
  logic        push;
  logic        pop;
  logic [13:0] push_entry;
  logic [13:0] head;

  assign accept = read_q && !io_Avalon_waitrequest;
  assign s_new  = io_Avalon_readdata[63:56];
  assign delta  = s_new - last_q;

  // Push decision uses the pre-pop count, so a full FIFO never pushes even
  // when it is being popped in the same cycle.
  assign push = (state_q == ST_UNPACK) && (count_q < CNT_W'(FIFO_DEPTH));
  assign pop  = (count_q != '0) && io_out_ready;

  // Entry layout: {lost, seq[7:0], info[4:0]}; byte k of the word is event S-k.
  assign push_entry = {lost_pend_q, word_q[63:56] - {5'd0, k_q}, word_q[{k_q, 3'b000} +: 5]};

  // Poll FSM: interval timer, Avalon read handshake and batch unpacking.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= TMR_W'(POLL_INTERVAL);
      read_q      <= 1'b0;
      last_q      <= 8'd0;
      k_q         <= 3'd0;
      lost_pend_q <= 1'b0;
      lost_cnt_q  <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end else if (io_enable) begin
            state_q <= ST_READ;
            read_q  <= 1'b1;
          end
        end
        ST_READ: begin
          if (accept) begin
            read_q <= 1'b0;
            word_q <= io_Avalon_readdata;
            last_q <= s_new;
            if (delta == 8'd0) begin
              state_q <= ST_IDLE;
              tmr_q   <= TMR_W'(POLL_INTERVAL);
            end else begin
              state_q     <= ST_UNPACK;
              k_q         <= (delta > 8'd7) ? 3'd6 : (delta[2:0] - 3'd1);
              lost_pend_q <= (delta > 8'd7);
              if (delta > 8'd7) begin
                lost_cnt_q <= sat_add16(lost_cnt_q, delta - 8'd7);
              end
            end
          end
        end
        ST_UNPACK: begin
          if (push) begin
            lost_pend_q <= 1'b0;
            if (k_q == 3'd0) begin
              state_q <= ST_IDLE;
              tmr_q   <= TMR_W'(POLL_INTERVAL);
            end else begin
              k_q <= k_q - 3'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tmr_q   <= TMR_W'(POLL_INTERVAL);
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign io_out_valid     = (count_q != '0);
  assign io_out_bits_info = io_out_valid ? head[4:0]  : 5'd0;
  assign io_out_bits_seq  = io_out_valid ? head[12:5] : 8'd0;
  assign io_out_bits_lost = io_out_valid ? head[13]   : 1'b0;
  assign io_lostCount     = lost_cnt_q;

  assign io_Avalon_read      = read_q;
  assign io_Avalon_address   = 1'b0;
  assign io_Avalon_write     = 1'b0;
  assign io_Avalon_writedata = 64'd0;

endmodule

// File: tb/tb_avalon_debug_log_reader.sv
// Directed bench for avalon_debug_log_reader: a simple Avalon slave returns
// hand-built trace words and the emitted event stream is compared with
// hand-computed expectations.
module tb_avalon_debug_log_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_enable;
  logic        io_Avalon_address;
  logic        io_Avalon_read;
  logic [63:0] word;
  logic        io_Avalon_write;
  logic [63:0] io_Avalon_writedata;
  logic        waitreq;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [4:0]  io_out_bits_info;
  logic [7:0]  io_out_bits_seq;
  logic        io_out_bits_lost;
  logic [15:0] io_lostCount;

  always #5 clock = ~clock;

  avalon_debug_log_reader #(.POLL_INTERVAL(16), .FIFO_DEPTH(8)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_enable             (io_enable),
    .io_Avalon_address     (io_Avalon_address),
    .io_Avalon_read        (io_Avalon_read),
    .io_Avalon_readdata    (word),
    .io_Avalon_write       (io_Avalon_write),
    .io_Avalon_writedata   (io_Avalon_writedata),
    .io_Avalon_waitrequest (waitreq),
    .io_out_valid          (io_out_valid),
    .io_out_ready          (io_out_ready),
    .io_out_bits_info      (io_out_bits_info),
    .io_out_bits_seq       (io_out_bits_seq),
    .io_out_bits_lost      (io_out_bits_lost),
    .io_lostCount          (io_lostCount)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cursor = 0;

  // Observed traffic, sampled on the falling edge.
  logic [13:0] got_q [$];
  int rdhi = 0;
  int acc  = 0;

  always @(negedge clock) begin
    if (io_Avalon_read) rdhi++;
    if (io_Avalon_read && !waitreq) acc++;
    if (io_out_valid && io_out_ready)
      got_q.push_back({io_out_bits_lost, io_out_bits_seq, io_out_bits_info});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for the next accepted read; returns 1 cycle after it.
  task automatic wait_accept(input string tag);
    int a0;
    bit ok;
    a0 = acc;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (acc > a0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_accept_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic drain();
    repeat (14) @(posedge clock);
    #1;
  endtask

  task automatic expect_entry(input string tag, input logic [4:0] info,
                              input logic [7:0] seq, input logic lost);
    logic [13:0] e;
    if (cursor < got_q.size()) begin
      e = got_q[cursor];
      chk({tag, "_info"}, 32'(e[4:0]), 32'(info));
      chk({tag, "_seq"},  32'(e[12:5]), 32'(seq));
      chk({tag, "_lost"}, 32'(e[13]), 32'(lost));
    end else begin
      chk({tag, "_present"}, got_q.size(), cursor + 1);
    end
    cursor++;
  endtask

  initial begin
    int first;
    int r0;
    int a0;
    int stalled;

    reset        = 1'b1;
    io_enable    = 1'b1;
    io_out_ready = 1'b1;
    waitreq      = 1'b0;
    word         = 64'h01_00_00_00_00_00_00_05;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_read",  32'(io_Avalon_read), 32'd0);
    chk("rst_valid", 32'(io_out_valid), 32'd0);
    chk("rst_lost_count", 32'(io_lostCount), 32'd0);
    chk("rst_info",  32'(io_out_bits_info), 32'd0);
    chk("rst_seq",   32'(io_out_bits_seq), 32'd0);
    chk("rst_lost",  32'(io_out_bits_lost), 32'd0);
    chk("rst_write", 32'(io_Avalon_write), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // First read cadence and single-event poll.
    first = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (io_Avalon_read && first < 0) first = c;
    end
    @(posedge clock);
    #1;
    chk("first_read_cycle", first, 32'd17);
    expect_entry("single", 5'h05, 8'd1, 1'b0);
    chk("single_lost_count", 32'(io_lostCount), 32'd0);

    // Same word again: nothing new.
    wait_accept("same");
    drain();
    chk("same_no_output", got_q.size(), cursor);

    // Two then three new events.
    word = 64'h03_00_00_00_00_01_02_03;
    wait_accept("two");
    drain();
    expect_entry("two0", 5'h02, 8'd2, 1'b0);
    expect_entry("two1", 5'h03, 8'd3, 1'b0);
    word = 64'h06_00_00_00_03_0A_0B_0C;
    wait_accept("multi");
    drain();
    expect_entry("multi0", 5'h0A, 8'd4, 1'b0);
    expect_entry("multi1", 5'h0B, 8'd5, 1'b0);
    expect_entry("multi2", 5'h0C, 8'd6, 1'b0);
    chk("multi_count", got_q.size(), cursor);

    // Reset after two of five pushes; the partial batch must vanish.
    io_out_ready = 1'b0;
    word = 64'h0B_00_00_05_04_03_02_01;
    wait_accept("pre_reset");
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    word = 64'h14_16_15_14_13_12_11_10;
    @(negedge clock);
    chk("pre_reset_valid", 32'(io_out_valid), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("mid_reset_valid", 32'(io_out_valid), 32'd0);
    chk("mid_reset_read", 32'(io_Avalon_read), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    io_out_ready = 1'b1;

    // Overflow from last=0 to S=20: seq 14..20, 13 lost.
    wait_accept("ovf");
    drain();
    for (int i = 0; i < 7; i++)
      expect_entry($sformatf("ovf%0d", i), 5'(8'h16 - i), 8'(14 + i), (i == 0));
    chk("ovf_count", got_q.size(), cursor);
    chk("ovf_lost_count", 32'(io_lostCount), 32'd13);

    // Second overflow, d=10.
    word = 64'h1E_18_00_00_00_00_00_00;
    wait_accept("ovf2");
    drain();
    expect_entry("ovf2_0", 5'h18, 8'd24, 1'b1);
    for (int i = 1; i < 7; i++)
      expect_entry($sformatf("ovf2_%0d", i), 5'h00, 8'(24 + i), 1'b0);
    chk("ovf2_lost_count", 32'(io_lostCount), 32'd16);

    // Move to last=254 (d=224, 217 lost), then wrap to S=1.
    word = 64'hFE_00_00_00_00_00_00_00;
    wait_accept("to254");
    drain();
    for (int i = 0; i < 7; i++)
      expect_entry($sformatf("to254_%0d", i), 5'h00, 8'(248 + i), (i == 0));
    chk("to254_lost_count", 32'(io_lostCount), 32'd233);
    word = 64'h01_00_00_00_00_07_08_09;
    wait_accept("wrap");
    drain();
    expect_entry("wrap0", 5'h07, 8'd255, 1'b0);
    expect_entry("wrap1", 5'h08, 8'd0, 1'b0);
    expect_entry("wrap2", 5'h09, 8'd1, 1'b0);
    chk("wrap_count", got_q.size(), cursor);
    chk("wrap_lost_count", 32'(io_lostCount), 32'd233);

    // Five waitrequest cycles on one read.
    waitreq = 1'b1;
    word = 64'h02_00_00_00_00_00_00_11;
    r0 = rdhi;
    a0 = acc;
    stalled = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (io_Avalon_read) begin
        stalled++;
        if (stalled == 5) break;
      end
    end
    @(posedge clock);
    #1 waitreq = 1'b0;
    wait_accept("stall");
    chk("stall_read_cycles", rdhi - r0, 32'd6);
    chk("stall_accepts", acc - a0, 32'd1);
    drain();
    expect_entry("stall0", 5'h11, 8'd2, 1'b0);

    // Back-pressure: two 7-entry batches into an 8-deep FIFO.
    io_out_ready = 1'b0;
    word = 64'h09_06_05_04_03_02_01_00;
    wait_accept("fill1");
    word = 64'h10_06_05_04_03_02_01_00;
    wait_accept("fill2");
    a0 = acc;
    repeat (40) @(posedge clock);
    #1;
    chk("fill_unpack_stalled", acc, a0);
    chk("fill_valid", 32'(io_out_valid), 32'd1);
    chk("fill_nothing_popped", got_q.size(), cursor);
    io_out_ready = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 7; i++)
        expect_entry($sformatf("fill%0d_%0d", b, i), 5'(6 - i), 8'(3 + 7 * b + i), 1'b0);
    chk("fill_count", got_q.size(), cursor);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
